// File: rtl/row_pair_averager.sv
// Streaming vertical 2-tap averager: every pixel of rows 1..ROWS-1 is averaged with the
// pixel directly above it, which is held in a one-row line buffer.
module row_pair_averager #(
    parameter int DW   = 8,
    parameter int COLS = 8,
    parameter int ROWS = 16,
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int OROW_W = (ROWS > 2) ? $clog2(ROWS - 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     data,
    input  logic              data_valid,
    input  logic              round_mode,
    output logic              valid,
    output logic [DW-1:0]     out,
    output logic [OROW_W-1:0] out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        AVG
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                round_q, round_d;

    logic                valid_q, valid_d;
    logic [DW-1:0]       out_q, out_d;
    logic [OROW_W-1:0]   out_row_q, out_row_d;
    logic [COL_W-1:0]    out_col_q, out_col_d;
    logic                done_q, done_d;

    logic [DW-1:0]       line_buf_q [COLS];

    logic                col_last;
    logic                row_last;
    logic [DW-1:0]       above;
    logic [DW:0]         sum;
    logic [DW:0]         sum_rnd;
    logic [DW-1:0]       avg;
    logic [ROW_W-1:0]    row_m1;

    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // The read of buf[col] sees the previous row even though the same entry is overwritten
    // at this edge with the current pixel.
    assign above   = line_buf_q[col_q];
    assign sum     = {1'b0, above} + {1'b0, data};
    assign sum_rnd = sum + {{DW{1'b0}}, round_q};
    assign avg     = DW'(sum_rnd >> 1);
    assign row_m1  = row_q - ROW_W'(1);

    // Raster position of the pixel presented this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        col_d = col_q;
        row_d = row_q;
        if (data_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (data_valid) begin
                    round_d = round_mode;
                    if (COLS == 1) begin
                        state_d = AVG;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (data_valid && col_last) begin
                    state_d = AVG;
                end
            end
            AVG: begin
                if (data_valid && col_last && row_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs hold their last value across stalls; only valid/done drop.
    always_comb begin
        valid_d   = data_valid && (state_q == AVG);
        out_d     = out_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        done_d    = 1'b0;
        if (valid_d) begin
            out_d     = avg;
            out_row_d = OROW_W'(row_m1);
            out_col_d = col_q;
            done_d    = col_last && row_last;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            round_q   <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            round_q   <= round_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            done_q    <= done_d;
        end
    end

    // NOTE: the line buffer is deliberately not reset; row 0 of every frame rewrites each
    // entry before AVG reads it, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (data_valid) begin
            line_buf_q[col_q] <= data;
        end
    end

    assign valid   = valid_q;
    assign out     = out_q;
    assign out_row = out_row_q;
    assign out_col = out_col_q;
    assign done    = done_q;

endmodule

// File: tb/tb_row_pair_averager.sv
// Scoreboard bench for row_pair_averager: the stimulus pushes expected outputs, a negedge
// monitor pops and compares them; a second instance covers the COLS=1, ROWS=2, DW=4 corner.
module tb_row_pair_averager;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       data_valid;
    logic       round_mode;
    logic       valid;
    logic [7:0] out;
    logic [3:0] out_row;
    logic [2:0] out_col;
    logic       done;

    logic [3:0] c_data;
    logic       c_dv;
    logic       c_rm;
    logic       c_valid;
    logic [3:0] c_out;
    logic [0:0] c_out_row;
    logic [0:0] c_out_col;
    logic       c_done;

    typedef struct packed {
        logic [7:0] pix;
        logic [3:0] row;
        logic [2:0] col;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   done_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic dv_last = 1'b0;

    always #5 clk = ~clk;

    row_pair_averager dut (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .round_mode(round_mode), .valid(valid), .out(out), .out_row(out_row),
        .out_col(out_col), .done(done)
    );

    row_pair_averager #(.DW(4), .COLS(1), .ROWS(2)) dut_c (
        .clk(clk), .reset(reset), .data(c_data), .data_valid(c_dv),
        .round_mode(c_rm), .valid(c_valid), .out(c_out), .out_row(c_out_row),
        .out_col(c_out_col), .done(c_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] avg_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic m);
        int s;
        s = int'(a) + int'(b) + int'(m);
        return 8'(s / 2);
    endfunction

    function automatic logic [7:0] pixel(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'(r * 16 + c);
            1:       return (r % 2 == 0) ? 8'h03 : 8'h04;
            2:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        dv_last <= data_valid;
    end

    // Monitor: every presented output must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid) begin
            check("valid_follows_accept", 32'(dv_last), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out=%0h row=%0d col=%0d, expected none",
                         out, out_row, out_col);
            end else begin
                e = exp_q.pop_front();
                check("out", 32'(out), 32'(e.pix));
                check("out_row", 32'(out_row), 32'(e.row));
                check("out_col", 32'(out_col), 32'(e.col));
                check("done", 32'(done), 32'(e.done));
            end
            if (done) done_cyc.push_back(cyc);
        end
        if (!reset && done && !valid) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid: got done=1 valid=0, expected done=0");
        end
    end

    task automatic idle_cycle();
        data_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic end_stream();
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Drives up to npix pixels of one frame; round_mode is inverted after the first pixel to
    // show that only the frame-start value matters.
    task automatic drive_frame(input logic mode, input int kind, input bit gaps, input int npix);
        logic [7:0] prev [8];
        logic [7:0] p;
        logic [7:0] e;
        int n;
        n = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (n < npix) begin
                    if (gaps && $urandom_range(0, 1) == 1) idle_cycle();
                    p = pixel(kind, r, c);
                    round_mode = (n == 0) ? mode : ~mode;
                    data = p;
                    data_valid = 1'b1;
                    if (r > 0) begin
                        e = (kind == 0 && mode == 1'b0) ? 8'((r - 1) * 16 + 8 + c)
                                                        : avg_model(prev[c], p, mode);
                        exp_q.push_back('{e, 4'(r - 1), 3'(c), (r == 15 && c == 7)});
                    end
                    prev[c] = p;
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        end
    endtask

    task automatic full_frame(input string name, input logic mode, input int kind,
                              input bit gaps);
        int d0;
        d0 = done_cyc.size();
        drive_frame(mode, kind, gaps, 128);
        end_stream();
        check({name, "_done_count"}, 32'(done_cyc.size() - d0), 32'd1);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, 32'(valid), 32'd0);
        check({name, "_out"}, 32'(out), 32'd0);
        check({name, "_out_row"}, 32'(out_row), 32'd0);
        check({name, "_out_col"}, 32'(out_col), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic corner_frame(input logic mode, input logic [3:0] exp_out);
        c_rm = mode;
        c_data = 4'hF;
        c_dv = 1'b1;
        @(posedge clk);
        #1;
        check("corner_no_early_valid", 32'(c_valid), 32'd0);
        c_data = 4'hE;
        c_rm = ~mode;
        @(posedge clk);
        #1;
        c_dv = 1'b0;
        check("corner_valid", 32'(c_valid), 32'd1);
        check("corner_out", 32'(c_out), 32'(exp_out));
        check("corner_done", 32'(c_done), 32'd1);
        check("corner_row", 32'(c_out_row), 32'd0);
        check("corner_col", 32'(c_out_col), 32'd0);
        @(posedge clk);
        #1;
        check("corner_valid_drop", 32'(c_valid), 32'd0);
        check("corner_out_hold", 32'(c_out), 32'(exp_out));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        reset = 1'b1;
        data = '0;
        data_valid = 1'b0;
        round_mode = 1'b0;
        c_data = '0;
        c_dv = 1'b0;
        c_rm = 1'b0;
        #12;
        check_idle_outputs("reset");
        check("reset_corner_valid", 32'(c_valid), 32'd0);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        full_frame("ramp", 1'b0, 0, 1'b0);
        full_frame("trunc_34", 1'b0, 1, 1'b0);
        full_frame("round_34", 1'b1, 1, 1'b0);
        full_frame("trunc_ff", 1'b0, 2, 1'b0);
        full_frame("round_ff", 1'b1, 2, 1'b0);
        full_frame("gaps", 1'b1, 3, 1'b1);

        // Reset between edges partway through row 5.
        drive_frame(1'b0, 0, 1'b0, 5 * 8 + 3);
        idle_cycle();
        @(negedge clk);
        #2;
        check("pre_reset_out", 32'(out), 32'd74);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        full_frame("post_reset", 1'b0, 3, 1'b0);

        n0 = done_cyc.size();
        drive_frame(1'b0, 3, 1'b0, 128);
        drive_frame(1'b1, 3, 1'b0, 128);
        end_stream();
        check("b2b_done_count", 32'(done_cyc.size() - n0), 32'd2);
        if (done_cyc.size() >= n0 + 2)
            check("b2b_done_spacing", 32'(done_cyc[n0 + 1] - done_cyc[n0]), 32'd128);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        corner_frame(1'b0, 4'hE);
        corner_frame(1'b1, 4'hF);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_pair_averager.md
Name: row_pair_averager

Overview:
- Streaming vertical 2-tap averager for raster-order pixel frames.
- Accepts one pixel per cycle when data_valid is high, buffers the previous row in a COLS-entry line buffer, and emits the mean of each vertically adjacent pixel pair.
- One frame of ROWS x COLS inputs yields (ROWS-1) x COLS outputs.
- Successor to the fixed 16x8, 8-bit row averager: parametrised size and width, true streaming, selectable rounding, frame-done signalling.

Parameters:
- DW, 8, pixel width in bits (>=2)
- COLS, 8, pixels per row (>=1)
- ROWS, 16, rows per frame (>=2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data  input  DW  input pixel, raster order (row-major)
- data_valid  input  1  data is a valid pixel this cycle; block is always ready
- round_mode  input  1  0 = truncate, 1 = round half up; sampled on first pixel of each frame
- valid  output  1  out carries an averaged pixel this cycle
- out  output  DW  averaged pixel
- out_row  output  clog2(ROWS-1)  output row index 0..ROWS-2 (width min 1)
- out_col  output  clog2(COLS)  output column index 0..COLS-1 (width min 1)
- done  output  1  one-cycle pulse coincident with the last output of a frame

Behaviour:
- Reset (async, any time, incl. mid-frame):
  - valid=0, out=0, out_row=0, out_col=0, done=0.
  - Counters are cleared; state=IDLE; latched round mode is cleared to 0.
  - Line buffer contents are not reset; the first row of the next frame overwrites them before any read.
- Counters: col 0..COLS-1 and row 0..ROWS-1 advance only on cycles with data_valid=1. col wraps to 0 and increments row at COLS-1.
- FSM states:
  - IDLE: waiting for first pixel. On data_valid: latch round_mode, write pixel to buf[0], col->1. Go to FILL, or to AVG if COLS==1.
  - FILL: row 0. Each valid pixel is written to buf[col]; no output. Last pixel of row 0 -> AVG.
  - AVG: rows 1..ROWS-1. Each valid pixel p at column c:
    - Compute sum = buf[c] + p in DW+1 bits.
    - Result = sum>>1 (truncate) or (sum+1)>>1 (round); (sum+1) cannot exceed DW+1 bits.
    - Register result to out; write p into buf[c] (read-before-write, same cycle).
    - Last pixel of row ROWS-1 -> IDLE.
- Latency: exactly 1 cycle. The pixel accepted at edge N gives valid=1 and out/out_row/out_col stable after edge N+1, held for one cycle only. out_row = input row - 1.
- Gaps: data_valid=0 stalls everything. valid=0 on the following cycle; out/out_row/out_col hold their last values.
- done: asserted with the valid of output (ROWS-2, COLS-1); never otherwise.
- Back-to-back frames: the pixel on the cycle after the final pixel is accepted as row 0 col 0 of the next frame, with no bubble. done of frame k and FILL of frame k+1 may overlap.
- round_mode changes mid-frame are ignored until the next frame start.
- Sizing: no overflow possible. Max output is 2^DW-1 (max+max, either mode).
- Line buffer: COLS x DW register array, one read port and one write port, same address per cycle.

Test Plan:
- Ramp, defaults (DW=8, COLS=8, ROWS=16), round_mode=0, data=row*16+col continuous -> 120 outputs; out=(2r+1)*16/2+c = r*16+8+c; done only on output (14,7).
- Truncate vs round: row0 all 0x03, row1 all 0x04 -> out=0x03 with round_mode=0, 0x04 with round_mode=1; all 0xFF pairs -> 0xFF in both modes.
- Random data_valid gaps (~50% duty) with random pixels -> output sequence identical to the gap-free golden model; valid never asserts during stalls; done exactly once.
- Async reset asserted mid-row 5 between clock edges -> all outputs 0 immediately. A fresh frame after release produces the correct 120 outputs, no stale-buffer influence.
- Two back-to-back frames with round_mode toggled at the boundary -> second frame uses the new mode; no lost or duplicated pixels; two done pulses 128 cycles apart.
- Corner sizing COLS=1, ROWS=2, DW=4: inputs 0xF, 0xE -> single output 0xE (truncate) / 0xF (round), with done=1 on the same cycle.
